// File: rtl/iiitb_gc_pkg.sv
// iiitb_gc_pkg: shared types, constants and helpers for the gray-counter receiver.
//   gc_state_t       : receiver FSM state encoding (INIT, RUN, PEND)
//   GC_WIDTH_DEFAULT : default gray/binary bus width
//   GC_SYNC_MIN      : minimum (and default) synchronizer depth
//   GC_MAX_WIDTH     : widest bus gray2bin handles
//   gray2bin()       : gray to binary conversion
package iiitb_gc_pkg;

  localparam int unsigned GC_WIDTH_DEFAULT = 8;
  localparam int unsigned GC_SYNC_MIN      = 2;
  localparam int unsigned GC_MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    PEND
  } gc_state_t;

  // Works on a zero-extended operand: leading zero gray bits leave the low
  // binary bits unchanged, so callers cast their narrower bus in and out.
  function automatic logic [GC_MAX_WIDTH-1:0] gray2bin(input logic [GC_MAX_WIDTH-1:0] g);
    logic [GC_MAX_WIDTH-1:0] b;
    b = '0;
    b[GC_MAX_WIDTH-1] = g[GC_MAX_WIDTH-1];
    for (int unsigned i = 1; i < GC_MAX_WIDTH; i++) begin
      b[GC_MAX_WIDTH-1-i] = b[GC_MAX_WIDTH-i] ^ g[GC_MAX_WIDTH-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/iiitb_gc_rx_if.sv
// iiitb_gc_rx_if: event handshake bundle from the gray receiver to its consumer.
//   evt_valid  : event pending (producer)
//   evt_ready  : consumer accepts the event (consumer)
//   evt_bin    : binary value carried by the event (producer)
//   evt_delta  : step since the last accepted value, mod 2^WIDTH (producer)
//   evt_merged : more than one change folded into this event (producer)
interface iiitb_gc_rx_if #(
  parameter int unsigned WIDTH = iiitb_gc_pkg::GC_WIDTH_DEFAULT
);

  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_bin;
  logic [WIDTH-1:0] evt_delta;
  logic             evt_merged;

  modport master (
    output evt_valid,
    output evt_bin,
    output evt_delta,
    output evt_merged,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_bin,
    input  evt_delta,
    input  evt_merged,
    output evt_ready
  );

endinterface

// File: rtl/iiitb_gc_sync.sv
// iiitb_gc_sync: WIDTH-bit x SYNC_STAGES flop chain bringing an asynchronous
// gray bus into the clk domain. Async active-low reset clears every stage.
//   clk    : sampling clock
//   reset  : asynchronous active-low reset
//   d_async: asynchronous input bus
//   q_sync : synchronized output (last stage)
module iiitb_gc_sync
  import iiitb_gc_pkg::*;
#(
  parameter int unsigned WIDTH       = GC_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = GC_SYNC_MIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] q_sync
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/iiitb_gc_rx.sv
// iiitb_gc_rx: gray-counter receiver. Synchronizes gray_in, converts it to
// binary and reports each change as a handshaked event with value and step.
// Changes arriving while an event waits for acceptance merge into it.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   enable    : event generation enable (synchronizer always runs)
//   gray_in   : asynchronous gray count, WIDTH bits
//   bin_count : registered binary of the synchronized gray value
//   step_err  : one-cycle pulse on a multi-bit gray step
//   evt       : event handshake (iiitb_gc_rx_if master)
// Build option: define IIITB_GC_RX_STEP_CHECK_EN to include the gray step
// checker; otherwise step_err is tied low.
// WIDTH must not exceed GC_MAX_WIDTH; SYNC_STAGES legal range is 2..4.
module iiitb_gc_rx
  import iiitb_gc_pkg::*;
#(
  parameter int unsigned WIDTH       = GC_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = GC_SYNC_MIN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  gray_in,
  output logic [WIDTH-1:0]  bin_count,
  output logic              step_err,
  iiitb_gc_rx_if.master     evt
);

  logic [WIDTH-1:0] w_gs;
  logic [WIDTH-1:0] w_bin;

  gc_state_t        r_state;
  logic [WIDTH-1:0] r_bin_count;
  logic [WIDTH-1:0] r_last_acc;
  logic [WIDTH-1:0] r_evt_bin;
  logic [WIDTH-1:0] r_evt_delta;
  logic             r_evt_merged;
  logic             r_evt_valid;

  iiitb_gc_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (gray_in),
    .q_sync  (w_gs)
  );

  assign w_bin = WIDTH'(gray2bin(GC_MAX_WIDTH'(w_gs)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= INIT;
      r_bin_count  <= '0;
      r_last_acc   <= '0;
      r_evt_bin    <= '0;
      r_evt_delta  <= '0;
      r_evt_merged <= 1'b0;
      r_evt_valid  <= 1'b0;
    end else begin
      r_bin_count <= w_bin;
      case (r_state)
        INIT: begin
          r_last_acc <= r_bin_count;
          r_state    <= RUN;
        end
        RUN: begin
          if (enable && (r_bin_count != r_last_acc)) begin
            r_evt_bin    <= r_bin_count;
            r_evt_delta  <= r_bin_count - r_last_acc;
            r_evt_merged <= 1'b0;
            r_evt_valid  <= 1'b1;
            r_state      <= PEND;
          end
        end
        PEND: begin
          // Accept wins over a same-cycle change; RUN picks that change up
          // next cycle because last_acc then differs from bin_count.
          if (evt.evt_ready) begin
            r_last_acc  <= r_evt_bin;
            r_evt_valid <= 1'b0;
            r_state     <= RUN;
          end else if (enable && (r_bin_count != r_evt_bin)) begin
            r_evt_bin    <= r_bin_count;
            r_evt_delta  <= r_bin_count - r_last_acc;
            r_evt_merged <= 1'b1;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bin_count      = r_bin_count;
  assign evt.evt_valid  = r_evt_valid;
  assign evt.evt_bin    = r_evt_bin;
  assign evt.evt_delta  = r_evt_delta;
  assign evt.evt_merged = r_evt_merged;

`ifdef IIITB_GC_RX_STEP_CHECK_EN
  logic [WIDTH-1:0] r_g_prev;
  logic             r_step_err;
  logic [WIDTH-1:0] w_gdiff;

  assign w_gdiff = w_gs ^ r_g_prev;

  // Registered from the same g_s that feeds bin_count, so the pulse lines
  // up with the bin_count update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_g_prev   <= '0;
      r_step_err <= 1'b0;
    end else begin
      r_g_prev   <= w_gs;
      r_step_err <= ($countones(w_gdiff) > 1);
    end
  end

  assign step_err = r_step_err;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_iiitb_gc_rx.sv
module tb_iiitb_gc_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] gray_in;
  logic [7:0] bin_count;
  logic       step_err;

`ifdef IIITB_GC_RX_STEP_CHECK_EN
  localparam logic STEP_EXP = 1'b1;
`else
  localparam logic STEP_EXP = 1'b0;
`endif

  iiitb_gc_rx_if #(.WIDTH(8)) evt_if ();

  iiitb_gc_rx #(
    .WIDTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .gray_in   (gray_in),
    .bin_count (bin_count),
    .step_err  (step_err),
    .evt       (evt_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  gray;
    logic        en;
    logic        rdy;
    int unsigned ncyc;
    logic        ev;
    logic [7:0]  eb;
    logic [7:0]  ed;
    logic        em;
    logic [7:0]  ecnt;
  } vec_t;

  localparam int unsigned NVEC = 23;
  vec_t vecs [NVEC];

  initial begin
    // gray, en, rdy, cycles -> valid, evt_bin, evt_delta, merged, bin_count
    // single step 0->1 (latency 4 from capture edge)
    vecs[0]  = '{8'h01, 1'b1, 1'b1, 3, 1'b0, 8'h00, 8'h00, 1'b0, 8'h01};
    vecs[1]  = '{8'h01, 1'b1, 1'b1, 1, 1'b1, 8'h01, 8'h01, 1'b0, 8'h01};
    vecs[2]  = '{8'h01, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h01};
    // backpressure merge 1 -> 2 -> 3 -> 4
    vecs[3]  = '{8'h03, 1'b1, 1'b0, 6, 1'b1, 8'h02, 8'h01, 1'b0, 8'h02};
    vecs[4]  = '{8'h02, 1'b1, 1'b0, 6, 1'b1, 8'h03, 8'h02, 1'b1, 8'h03};
    vecs[5]  = '{8'h06, 1'b1, 1'b0, 6, 1'b1, 8'h04, 8'h03, 1'b1, 8'h04};
    vecs[6]  = '{8'h06, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h04};
    vecs[7]  = '{8'h06, 1'b1, 1'b1, 3, 1'b0, 8'h00, 8'h00, 1'b0, 8'h04};
    // wrap: 4 -> 254 -> 255 -> 0
    vecs[8]  = '{8'h81, 1'b1, 1'b1, 4, 1'b1, 8'hFE, 8'hFA, 1'b0, 8'hFE};
    vecs[9]  = '{8'h81, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFE};
    vecs[10] = '{8'h80, 1'b1, 1'b1, 4, 1'b1, 8'hFF, 8'h01, 1'b0, 8'hFF};
    vecs[11] = '{8'h80, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF};
    vecs[12] = '{8'h00, 1'b1, 1'b1, 4, 1'b1, 8'h00, 8'h01, 1'b0, 8'h00};
    vecs[13] = '{8'h00, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    // enable gating, accumulated delta on re-enable
    vecs[14] = '{8'h01, 1'b0, 1'b1, 6, 1'b0, 8'h00, 8'h00, 1'b0, 8'h01};
    vecs[15] = '{8'h03, 1'b0, 1'b1, 6, 1'b0, 8'h00, 8'h00, 1'b0, 8'h02};
    vecs[16] = '{8'h03, 1'b1, 1'b1, 1, 1'b1, 8'h02, 8'h02, 1'b0, 8'h02};
    vecs[17] = '{8'h03, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h02};
    // pending event: no merge while disabled, still completes on ready
    vecs[18] = '{8'h02, 1'b1, 1'b0, 6, 1'b1, 8'h03, 8'h01, 1'b0, 8'h03};
    vecs[19] = '{8'h06, 1'b0, 1'b0, 6, 1'b1, 8'h03, 8'h01, 1'b0, 8'h04};
    vecs[20] = '{8'h06, 1'b0, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h04};
    vecs[21] = '{8'h06, 1'b1, 1'b1, 1, 1'b1, 8'h04, 8'h01, 1'b0, 8'h04};
    vecs[22] = '{8'h06, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h04};

    reset            = 1'b0;
    enable           = 1'b1;
    gray_in          = 8'h00;
    evt_if.evt_ready = 1'b1;
    cycles(3);
    chk("rst.valid",     32'(evt_if.evt_valid),  32'(1'b0));
    chk("rst.merged",    32'(evt_if.evt_merged), 32'(1'b0));
    chk("rst.bin_count", 32'(bin_count),         32'(8'h00));
    chk("rst.evt_bin",   32'(evt_if.evt_bin),    32'(8'h00));
    chk("rst.evt_delta", 32'(evt_if.evt_delta),  32'(8'h00));
    chk("rst.step_err",  32'(step_err),          32'(1'b0));

    reset = 1'b1;
    cycles(3);
    chk("base.bin_count", 32'(bin_count),        32'(8'h00));
    chk("base.valid",     32'(evt_if.evt_valid), 32'(1'b0));

    for (int i = 0; i < NVEC; i++) begin
      gray_in          = vecs[i].gray;
      enable           = vecs[i].en;
      evt_if.evt_ready = vecs[i].rdy;
      cycles(vecs[i].ncyc);
      chk($sformatf("v%0d.valid", i),     32'(evt_if.evt_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.bin_count", i), 32'(bin_count),        32'(vecs[i].ecnt));
      chk($sformatf("v%0d.step_err", i),  32'(step_err),         32'(1'b0));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d.evt_bin", i),   32'(evt_if.evt_bin),    32'(vecs[i].eb));
        chk($sformatf("v%0d.evt_delta", i), 32'(evt_if.evt_delta),  32'(vecs[i].ed));
        chk($sformatf("v%0d.merged", i),    32'(evt_if.evt_merged), 32'(vecs[i].em));
      end
    end

    // Accept on the same edge that bin_count moves: one-cycle gap, no loss.
    evt_if.evt_ready = 1'b0;
    gray_in          = 8'h07;
    cycles(6);
    chk("sc.pend.valid", 32'(evt_if.evt_valid), 32'(1'b1));
    chk("sc.pend.bin",   32'(evt_if.evt_bin),   32'(8'h05));
    gray_in = 8'h05;
    cycles(2);
    chk("sc.hold.bin",   32'(evt_if.evt_bin),   32'(8'h05));
    evt_if.evt_ready = 1'b1;
    cycles(1);
    chk("sc.acc.valid",  32'(evt_if.evt_valid), 32'(1'b0));
    chk("sc.acc.cnt",    32'(bin_count),        32'(8'h06));
    cycles(1);
    chk("sc.new.valid",  32'(evt_if.evt_valid),  32'(1'b1));
    chk("sc.new.bin",    32'(evt_if.evt_bin),    32'(8'h06));
    chk("sc.new.delta",  32'(evt_if.evt_delta),  32'(8'h01));
    chk("sc.new.merged", 32'(evt_if.evt_merged), 32'(1'b0));
    cycles(1);
    chk("sc.done.valid", 32'(evt_if.evt_valid), 32'(1'b0));

    // Two-bit gray step 0x05 -> 0x06 (bin 6 -> 4).
    gray_in = 8'h06;
    cycles(2);
    chk("ill.pre.step_err",  32'(step_err),          32'(1'b0));
    cycles(1);
    chk("ill.step_err",      32'(step_err),          32'(STEP_EXP));
    chk("ill.cnt",           32'(bin_count),         32'(8'h04));
    cycles(1);
    chk("ill.post.step_err", 32'(step_err),          32'(1'b0));
    chk("ill.valid",         32'(evt_if.evt_valid),  32'(1'b1));
    chk("ill.bin",           32'(evt_if.evt_bin),    32'(8'h04));
    chk("ill.delta",         32'(evt_if.evt_delta),  32'(8'hFE));
    cycles(1);
    chk("ill.done.valid",    32'(evt_if.evt_valid),  32'(1'b0));

    // Reset while an event is pending drops it.
    evt_if.evt_ready = 1'b0;
    gray_in          = 8'h07;
    cycles(6);
    chk("mr.pend.valid", 32'(evt_if.evt_valid), 32'(1'b1));
    reset   = 1'b0;
    gray_in = 8'h00;
    #1;
    chk("mr.valid",  32'(evt_if.evt_valid),  32'(1'b0));
    chk("mr.cnt",    32'(bin_count),         32'(8'h00));
    chk("mr.bin",    32'(evt_if.evt_bin),    32'(8'h00));
    chk("mr.delta",  32'(evt_if.evt_delta),  32'(8'h00));
    chk("mr.merged", 32'(evt_if.evt_merged), 32'(1'b0));
    @(negedge clk);
    reset            = 1'b1;
    evt_if.evt_ready = 1'b1;
    cycles(6);
    chk("mr.after.valid", 32'(evt_if.evt_valid), 32'(1'b0));
    chk("mr.after.cnt",   32'(bin_count),        32'(8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iiitb_gc_rx.md
Name: iiitb_gc_rx

Overview:
Downstream consumer of the 8-bit gray counter output. Synchronizes the gray bus into the local clock domain, converts it to binary, and detects changes. Each change is reported as an event carrying the new value and the step size since the last accepted event, over a valid/ready handshake. Events merge under backpressure, and an optional checker flags illegal multi-bit gray transitions.

Parameters:
WIDTH, 8, gray/binary bus width.
SYNC_STAGES, 2, synchronizer flop depth (legal values 2–4).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous active-low reset: 0 resets the block, 1 means run.
enable  in  1  event generation enable; the synchronizer runs regardless.
gray_in  in  WIDTH  gray count from the upstream counter, treated as asynchronous.
bin_count  out  WIDTH  registered binary of the synchronized gray value.
evt_valid  out  1  event pending.
evt_ready  in  1  consumer accepts the event.
evt_bin  out  WIDTH  binary value of the pending event.
evt_delta  out  WIDTH  (evt_bin − last accepted value) mod 2^WIDTH.
evt_merged  out  1  more than one change folded into the pending event.
step_err  out  1  one-cycle pulse on an illegal gray step (feature-dependent).

Behaviour:
- Reset (reset=0, asynchronous):
  - sync chain, bin_count, evt_bin, evt_delta and the last_acc register clear to 0.
  - evt_valid, evt_merged and step_err clear to 0.
  - state = INIT.
- Pipeline:
  - gray_in passes through SYNC_STAGES flops to give g_s.
  - bin_count = gray2bin(g_s), registered one cycle later.
  - Edge-to-evt_valid latency = SYNC_STAGES+2 clocks from the first clk edge that captures the new gray_in.
- gray2bin: b[W−1] = g[W−1]; b[i] = b[i+1] ^ g[i].
- FSM:
  - INIT: first cycle after reset release loads last_acc = bin_count and moves to RUN. No event is generated.
  - RUN: if enable and bin_count ≠ last_acc, load evt_bin = bin_count and evt_delta = bin_count − last_acc (mod 2^W), clear evt_merged, assert evt_valid, and go to PEND.
  - PEND: evt_valid=1.
    - If evt_ready: last_acc ← evt_bin, evt_valid deasserts next cycle, go to RUN.
    - Else, if enable and bin_count ≠ evt_bin: evt_bin ← bin_count, evt_delta ← bin_count − last_acc, evt_merged ← 1.
  - Same-cycle accept and new change: the accept completes with the old payload and the new change becomes a fresh event in RUN on the following cycle. No change is lost; at most one cycle of evt_valid=0 separates the two events.
- evt_bin, evt_delta and evt_merged are stable while evt_valid=1 and evt_ready=0, except for merge updates.
- enable=0:
  - No new event is generated and a pending event is not merged.
  - A pending event still completes on evt_ready.
  - last_acc is untouched, so re-enabling with a changed value yields one event carrying the full accumulated delta.
- Wrap-around: 255→0 gives delta 1 (mod arithmetic). A net delta of 0 after a full lap is invisible by design.
- Reset mid-event drops the pending event silently.

Optional Feature:
Macro: IIITB_GC_RX_STEP_CHECK_EN.
- Defined: register the previous g_s. If popcount(g_s ^ g_prev) > 1, pulse step_err for 1 cycle, aligned with the bin_count update. Event behaviour is unaffected.
- Undefined: no checker logic; step_err tied to 0.

Decomposition:
- Package iiitb_gc_pkg holds:
  - state enum {INIT, RUN, PEND};
  - function gray2bin;
  - constant GC_WIDTH_DEFAULT = 8;
  - constant GC_SYNC_MIN = 2.
- Sub-module iiitb_gc_sync: parameterized WIDTH × SYNC_STAGES flop chain with async active-low reset to 0.

Test Plan:
1. Reset and baseline: hold reset=0 with gray_in=0x00, enable=1 → all outputs 0. Release reset → bin_count=0 after 3 clocks and evt_valid stays 0.
2. Single step: gray_in 0x00→0x01 with evt_ready=1 → evt_valid=1 on the 4th edge after capture, evt_bin=1, evt_delta=1, evt_merged=0; evt_valid low the next cycle.
3. Backpressure merge: evt_ready=0, gray_in 0x01, 0x03, 0x02 spaced 6 clocks apart → evt_valid held high with evt_bin=3, evt_delta=3, evt_merged=1. Raise evt_ready → one accept, last_acc=3.
4. Wrap: baseline 254 (0x81), step to 0x80 then 0x00 with evt_ready=1 → events (255, 1) then (0, 1).
5. Enable gating: enable=0, gray_in steps 0x00→0x01→0x03 → no events. Set enable=1 → one event with evt_bin=2, evt_delta=2.
6. Illegal step: gray_in 0x00→0x03 → with the macro defined, step_err pulses 1 cycle and an event with evt_bin=2 is still generated; with the macro undefined, step_err stays 0.
